// File: rtl/cdc_handshake_rx_pkg.sv
// Shared definitions for the destination side of the 4-phase req/ack bus CDC.
// The FSM encoding and the default word width are kept here so that the
// integration wrapper (which also instantiates the 1-bit req synchroniser)
// sees the same values.
package cdc_handshake_rx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // IDLE : waiting for a synchronised request
  // HOLD : word captured, offered to the consumer
  // ACK  : word delivered, ack raised until req drops
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Even parity check: 1 when data plus its parity bit has odd weight.
  function automatic logic parity_mismatch(input logic par_bit, input logic odd_weight);
    return odd_weight ^ par_bit;
  endfunction

endpackage

// File: rtl/cdc_handshake_rx.sv
// Destination endpoint of a 4-phase req/ack bus-transfer CDC.
// Captures the source's held-stable bus once per request, offers it on a
// valid/ready interface, then raises ack until the synchronised req drops.
// ack_o comes straight from a flop so the source side can synchronise it.
// Optional feature: define CDC_HANDSHAKE_RX_PARITY_EN to add parity_i and
// parity_err_o (even parity over data_i, checked at capture).
import cdc_handshake_rx_pkg::*;

module cdc_handshake_rx #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef CDC_HANDSHAKE_RX_PARITY_EN
  input  logic                  parity_i,
  output logic                  parity_err_o,
`endif
  input  logic                  req_sync_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ack_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ack_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Capture only happens from IDLE; acceptance only once the word is visible.
  logic capture, accept;
  assign capture = (state_q == ST_IDLE) && req_sync_i;
  assign accept  = (state_q == ST_HOLD) && valid_q && ready_i;

  // State register; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode. A req that drops during HOLD is a source violation;
  // delivery still completes and ACK then exits on the following cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_sync_i) state_d = ST_HOLD;
      ST_HOLD: if (accept)     state_d = ST_ACK;
      ST_ACK:  if (!req_sync_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered datapath: word/valid on capture, ack and count on acceptance,
  // ack release once the source has withdrawn its request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (capture) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end
      if (accept) begin
        valid_q <= 1'b0;
        ack_q   <= 1'b1;
        cnt_q   <= cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == ST_ACK) && !req_sync_i) ack_q <= 1'b0;
    end
  end

`ifdef CDC_HANDSHAKE_RX_PARITY_EN
  logic perr_q;

  // Parity flag travels with the captured word and clears when it is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i)        perr_q <= 1'b0;
    else if (capture) perr_q <= parity_mismatch(parity_i, ^data_i);
    else if (accept)  perr_q <= 1'b0;
  end

  assign parity_err_o = perr_q;
`endif

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign ack_o      = ack_q;
  assign xfer_cnt_o = cnt_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx (CNT_WIDTH=8 so the counter wraps).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_cdc_handshake_rx;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid;
  logic          ready;
  logic          ack;
  logic [CW-1:0] cnt;
  logic          busy;
`ifdef CDC_HANDSHAKE_RX_PARITY_EN
  logic          par;
  logic          perr;
`endif

  int total = 0;
  int bad   = 0;
  int accepts = 0;

  cdc_handshake_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef CDC_HANDSHAKE_RX_PARITY_EN
    .parity_i   (par),
    .parity_err_o(perr),
`endif
    .req_sync_i (req),
    .data_i     (din),
    .data_o     (dout),
    .valid_o    (valid),
    .ready_i    (ready),
    .ack_o      (ack),
    .xfer_cnt_o (cnt),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Independent count of consumer handshakes seen on the interface.
  always @(posedge clk) begin
    if (rst) accepts = 0;
    else if (valid === 1'b1 && ready === 1'b1) accepts = accepts + 1;
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return DW'(32'h9E37_79B9 * (i + 1)) ^ DW'(i);
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; din = '0; ready = 1'b0;
`ifdef CDC_HANDSHAKE_RX_PARITY_EN
    par = 1'b0;
`endif
    tick(2);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_data",  64'(dout),  0);
    chk("rst_cnt",   64'(cnt),   0);
    rst = 1'b0;

    // 1: idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 64'(valid), 0);
      chk("idle_ack",   64'(ack),   0);
      chk("idle_busy",  64'(busy),  0);
      chk("idle_cnt",   64'(cnt),   0);
    end

    // 2: single transfer, ready tied high
    ready = 1'b1; din = 32'hDEADBEEF; req = 1'b1;
    tick();
    chk("t2_valid", 64'(valid), 1);
    chk("t2_data",  64'(dout),  64'hDEADBEEF);
    chk("t2_ack0",  64'(ack),   0);
    chk("t2_busy",  64'(busy),  1);
    tick();
    chk("t2_valid0", 64'(valid), 0);
    chk("t2_ack1",   64'(ack),   1);
    chk("t2_cnt",    64'(cnt),   1);
    tick(2);
    chk("t2_ackhold", 64'(ack), 1);
    req = 1'b0;
    tick();
    chk("t2_ackdrop", 64'(ack),  0);
    chk("t2_idle",    64'(busy), 0);
    chk("t2_cnt2",    64'(cnt),  1);

    // 3: backpressure; source bus changes but captured word must not
    ready = 1'b0; din = 32'hDEADBEEF; req = 1'b1;
    tick();
    chk("t3_valid", 64'(valid), 1);
    din = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t3_frozen", 64'(dout),  64'hDEADBEEF);
      chk("t3_ack0",   64'(ack),   0);
      chk("t3_vhold",  64'(valid), 1);
    end
    ready = 1'b1;
    tick();
    chk("t3_ack1", 64'(ack), 1);
    chk("t3_cnt",  64'(cnt), 2);
    req = 1'b0;
    tick();
    chk("t3_idle", 64'(busy), 0);

    // 4: 300 back-to-back transfers from a fresh reset; counter wraps to 44
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      din = word(i); req = 1'b1; ready = (i % 3 != 0);
      tick();
      chk("t4_valid", 64'(valid), 1);
      chk("t4_data",  64'(dout),  64'(word(i)));
      if (!ready) begin
        din = ~word(i);
        tick();
        chk("t4_bp", 64'(dout), 64'(word(i)));
        ready = 1'b1;
      end
      tick();
      chk("t4_ack", 64'(ack), 1);
      chk("t4_cnt", 64'(cnt), 64'((i + 1) % 256));
      req = 1'b0;
      tick();
      chk("t4_ackdrop", 64'(ack), 0);
    end
    chk("t4_final_cnt", 64'(cnt), 44);
    chk("t4_accepts",   64'(accepts), 300);

    // 5: reset during HOLD with req still high
    din = 32'hA5A5_5A5A; req = 1'b1; ready = 1'b0;
    tick();
    chk("t5_hold", 64'(valid), 1);
    rst = 1'b1;
    tick();
    chk("t5_rvalid", 64'(valid), 0);
    chk("t5_rdata",  64'(dout),  0);
    chk("t5_rack",   64'(ack),   0);
    chk("t5_rcnt",   64'(cnt),   0);
    chk("t5_rbusy",  64'(busy),  0);
    rst = 1'b0;
    tick();
    chk("t5_recap",  64'(valid), 1);
    chk("t5_redata", 64'(dout),  64'hA5A5_5A5A);
    chk("t5_cnt0",   64'(cnt),   0);
    ready = 1'b1;
    tick();
    chk("t5_cnt1", 64'(cnt), 1);
    req = 1'b0;
    tick();

    // req withdrawn during HOLD: delivery completes, ACK lasts one cycle
    din = 32'h0F0F_0F0F; req = 1'b1; ready = 1'b0;
    tick();
    req = 1'b0;
    tick();
    chk("pv_valid", 64'(valid), 1);
    ready = 1'b1;
    tick();
    chk("pv_ack",  64'(ack), 1);
    chk("pv_cnt",  64'(cnt), 2);
    tick();
    chk("pv_ack0", 64'(ack),  0);
    chk("pv_idle", 64'(busy), 0);

`ifdef CDC_HANDSHAKE_RX_PARITY_EN
    // 6: parity checking on a single-bit word
    din = 32'h0000_0001; par = 1'b0; req = 1'b1; ready = 1'b0;
    tick();
    chk("p_err1", 64'(perr), 1);
    ready = 1'b1;
    tick();
    chk("p_clr", 64'(perr), 0);
    req = 1'b0;
    tick();
    par = 1'b1; req = 1'b1; ready = 1'b0;
    tick();
    chk("p_err0", 64'(perr), 0);
    ready = 1'b1;
    tick();
    req = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
